mc_control_unit: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath; the successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/execute/memory/writeback states and drives the shared-ALU, single-memory datapath. It stalls on a memory-ready handshake and supports optional addi and j. An illegal-opcode flag lets the top level trap undecoded instructions.

---
 rtl/mc_control_unit_pkg.sv | 55 +++++
 rtl/mc_control_unit_if.sv | 34 +++
 rtl/mc_control_unit.sv | 143 ++++++++++++++
 tb/tb_mc_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control FSM.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface mc_control_unit_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       illegal_op;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, illegal_op, state_dbg
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, illegal_op, state_dbg
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main control: Moore FSM with a memory-ready stall and a
// one-cycle illegal-opcode pulse out of DECODE.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit ENABLE_ADDI = 1'b1,
   parameter bit ENABLE_JUMP = 1'b1
) (
   input logic               clk,
   input logic               reset,
   mc_control_unit_if.master bus
);

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   ctrl_t      ctl;
   logic       illegal;
   logic       mem_done;

   assign mem_done = bus.mem_ready || !MEM_WAIT_EN;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ctl     = '0;
      illegal = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.alu_op    = ALUOP_ADD;
            ctl.pc_source = PCSRC_ALU;
            if (mem_done) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            ctl.alu_src_b = SRCB_IMM_SH;
            op_d          = bus.opcode;
            illegal       = 1'b1;
            state_d       = S_FETCH;
            case (bus.opcode)
               OP_RTYPE:     begin illegal = 1'b0; state_d = S_EXEC;   end
               OP_LW, OP_SW: begin illegal = 1'b0; state_d = S_MEMADR; end
               OP_BEQ:       begin illegal = 1'b0; state_d = S_BRANCH; end
               OP_ADDI: if (ENABLE_ADDI) begin illegal = 1'b0; state_d = S_ADDIEX; end
               OP_J:    if (ENABLE_JUMP) begin illegal = 1'b0; state_d = S_JUMP;   end
               default: ;
            endcase
         end
         S_MEMADR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            // Latched opcode: the IR input may already be changing here.
            state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (mem_done) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEMWR: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
            if (mem_done) state_d = S_FETCH;
         end
         S_EXEC: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_B;
            ctl.alu_op    = ALUOP_FUNCT;
            state_d       = S_ALUWB;
         end
         S_ALUWB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = SRCB_B;
            ctl.alu_op        = ALUOP_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = PCSRC_ALUOUT;
            state_d           = S_FETCH;
         end
         S_ADDIEX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            state_d       = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctl.reg_write = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PCSRC_JUMP;
            state_d       = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset silences every strobe immediately, aborting any in-flight access.
      if (reset) begin
         ctl     = '0;
         illegal = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   assign bus.PCWrite     = ctl.pc_write;
   assign bus.PCWriteCond = ctl.pc_write_cond;
   assign bus.IorD        = ctl.iord;
   assign bus.MemRead     = ctl.mem_read;
   assign bus.MemWrite    = ctl.mem_write;
   assign bus.IRWrite     = ctl.ir_write;
   assign bus.MemtoReg    = ctl.mem_to_reg;
   assign bus.RegDst      = ctl.reg_dst;
   assign bus.RegWrite    = ctl.reg_write;
   assign bus.ALUSrcA     = ctl.alu_src_a;
   assign bus.ALUSrcB     = ctl.alu_src_b;
   assign bus.ALUOp       = ctl.alu_op;
   assign bus.PCSource    = ctl.pc_source;
   assign bus.illegal_op  = illegal;
   assign bus.state_dbg   = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference sequences with random
// stalls/opcodes across three parameter sets, compared every cycle.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;

   always #5 clk = ~clk;

   mc_control_unit_if b0();
   mc_control_unit_if b1();
   mc_control_unit_if b2();

   assign b0.opcode = opcode;  assign b0.mem_ready = mem_ready;
   assign b1.opcode = opcode;  assign b1.mem_ready = mem_ready;
   assign b2.opcode = opcode;  assign b2.mem_ready = mem_ready;

   mc_control_unit #(.MEM_WAIT_EN(1'b1), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1))
      dut0 (.clk(clk), .reset(reset), .bus(b0));
   mc_control_unit #(.MEM_WAIT_EN(1'b0), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1))
      dut1 (.clk(clk), .reset(reset), .bus(b1));
   mc_control_unit #(.MEM_WAIT_EN(1'b1), .ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0))
      dut2 (.clk(clk), .reset(reset), .bus(b2));

   // {state[20:17], illegal[16], PCWrite[15], PCWriteCond[14], IorD[13],
   //  MemRead[12], MemWrite[11], IRWrite[10], MemtoReg[9], RegDst[8],
   //  RegWrite[7], ALUSrcA[6], ALUSrcB[5:4], ALUOp[3:2], PCSource[1:0]}
   logic [20:0] obs [3];
   assign obs[0] = {b0.state_dbg, b0.illegal_op, b0.PCWrite, b0.PCWriteCond, b0.IorD,
                    b0.MemRead, b0.MemWrite, b0.IRWrite, b0.MemtoReg, b0.RegDst,
                    b0.RegWrite, b0.ALUSrcA, b0.ALUSrcB, b0.ALUOp, b0.PCSource};
   assign obs[1] = {b1.state_dbg, b1.illegal_op, b1.PCWrite, b1.PCWriteCond, b1.IorD,
                    b1.MemRead, b1.MemWrite, b1.IRWrite, b1.MemtoReg, b1.RegDst,
                    b1.RegWrite, b1.ALUSrcA, b1.ALUSrcB, b1.ALUOp, b1.PCSource};
   assign obs[2] = {b2.state_dbg, b2.illegal_op, b2.PCWrite, b2.PCWriteCond, b2.IorD,
                    b2.MemRead, b2.MemWrite, b2.IRWrite, b2.MemtoReg, b2.RegDst,
                    b2.RegWrite, b2.ALUSrcA, b2.ALUSrcB, b2.ALUOp, b2.PCSource};

   bit wait_en [3] = '{1'b1, 1'b0, 1'b1};
   bit addi_en [3] = '{1'b1, 1'b1, 1'b0};
   bit jump_en [3] = '{1'b1, 1'b1, 1'b0};

   int errors = 0;
   int checks = 0;
   int memw_cnt, memrd_cnt, irw_cnt, regw_cnt, pcw_cnt, ill_cnt;

   typedef struct {
      int         st;
      bit         mr;
      bit         ill;
      logic [5:0] op;
   } step_t;
   step_t q[$];

   function automatic bit legal(int sel, logic [5:0] op);
      return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 ||
             (op == 6'd8 && addi_en[sel]) || (op == 6'd2 && jump_en[sel]);
   endfunction

   // Expected Moore outputs straight from the per-state table.
   function automatic logic [20:0] exp_vec(int st, bit done, bit ill);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rdst = 0, rw = 0, sa = 0;
      logic [1:0] sb = 0, aop = 0, pcs = 0;
      case (st)
         0:  begin mrd = 1; sb = 2'b01; if (done) begin irw = 1; pcw = 1; end end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin sa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {4'(st), ill, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs};
   endfunction

   task automatic push(int st, bit mr, bit ill, logic [5:0] op);
      step_t s;
      s.st = st; s.mr = mr; s.ill = ill; s.op = op;
      q.push_back(s);
   endtask

   // A memory state: w stalled cycles then the completing one (one cycle if no waiting).
   task automatic push_mem(int sel, int st, int w);
      if (wait_en[sel]) begin
         repeat (w) push(st, 1'b0, 1'b0, 6'($urandom));
         push(st, 1'b1, 1'b0, 6'($urandom));
      end else begin
         push(st, 1'($urandom), 1'b0, 6'($urandom));
      end
   endtask

   task automatic gen_instr(int sel, logic [5:0] op, int wf, int wm);
      bit ok = legal(sel, op);
      push_mem(sel, 0, wf);
      push(1, 1'($urandom), !ok, op);
      if (ok) begin
         case (op)
            6'd0:  begin push(6, 1'($urandom), 0, 6'($urandom)); push(7, 1'($urandom), 0, 6'($urandom)); end
            6'd35: begin push(2, 1'($urandom), 0, 6'($urandom)); push_mem(sel, 3, wm);
                         push(4, 1'($urandom), 0, 6'($urandom)); end
            6'd43: begin push(2, 1'($urandom), 0, 6'($urandom)); push_mem(sel, 5, wm); end
            6'd4:  push(8, 1'($urandom), 0, 6'($urandom));
            6'd8:  begin push(9, 1'($urandom), 0, 6'($urandom)); push(10, 1'($urandom), 0, 6'($urandom)); end
            default: push(11, 1'($urandom), 0, 6'($urandom));
         endcase
      end
   endtask

   task automatic run(int sel, int n);
      int lim = (n < 0 || n > q.size()) ? q.size() : n;
      logic [20:0] e;
      memw_cnt = 0; memrd_cnt = 0; irw_cnt = 0; regw_cnt = 0; pcw_cnt = 0; ill_cnt = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         reset = 1'b0; opcode = q[i].op; mem_ready = q[i].mr;
         #1;
         e = exp_vec(q[i].st, q[i].mr || !wait_en[sel], q[i].ill);
         checks++;
         assert (obs[sel] === e) else begin
            errors++;
            $error("FAIL seq dut%0d step%0d state%0d: got %h want %h", sel, i, q[i].st, obs[sel], e);
         end
         if (obs[sel][11] === 1'b1) memw_cnt++;
         if (obs[sel][12] === 1'b1) memrd_cnt++;
         if (obs[sel][10] === 1'b1) irw_cnt++;
         if (obs[sel][7]  === 1'b1) regw_cnt++;
         if (obs[sel][15] === 1'b1) pcw_cnt++;
         if (obs[sel][16] === 1'b1) ill_cnt++;
      end
      q.delete();
   endtask

   task automatic do_reset(int sel, int n);
      repeat (n) begin
         @(negedge clk);
         reset = 1'b1; opcode = 6'($urandom); mem_ready = 1'($urandom);
         #1;
         checks++;
         assert (obs[sel] === 21'd0) else begin
            errors++;
            $error("FAIL reset dut%0d: got %h want 0", sel, obs[sel]);
         end
      end
   endtask

   task automatic check_cnt(string tag, int got, int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   initial begin
      reset = 1'b1; opcode = '0; mem_ready = 1'b0;
      do_reset(0, 2);

      // lw, no stalls: 0,1,2,3,4 then back to FETCH
      gen_instr(0, 6'd35, 0, 0); run(0, -1);
      check_cnt("lw_irwrite", irw_cnt, 1);
      check_cnt("lw_regwrite", regw_cnt, 1);
      gen_instr(0, 6'd0, 0, 0); run(0, 1);

      // sw with two stalled MEMWR cycles
      do_reset(0, 1);
      gen_instr(0, 6'd43, 0, 2); run(0, -1);
      check_cnt("sw_memwrite_wait", memw_cnt, 3);
      do_reset(1, 1);
      gen_instr(1, 6'd43, 0, 2); run(1, -1);
      check_cnt("sw_memwrite_nowait", memw_cnt, 1);

      // FETCH stalled 3 cycles
      do_reset(0, 1);
      gen_instr(0, 6'd0, 3, 0); run(0, -1);
      check_cnt("fetch_memread", memrd_cnt, 4);
      check_cnt("fetch_irwrite", irw_cnt, 1);
      check_cnt("fetch_pcwrite", pcw_cnt, 1);

      // beq
      gen_instr(0, 6'd4, 0, 0); run(0, -1);

      // illegal opcodes on the reduced-ISA instance
      do_reset(2, 1);
      gen_instr(2, 6'd63, 0, 0); gen_instr(2, 6'd8, 1, 0); gen_instr(2, 6'd2, 0, 0);
      run(2, -1);
      check_cnt("illegal_pulses", ill_cnt, 3);
      check_cnt("illegal_regwrite", regw_cnt, 0);
      check_cnt("illegal_memwrite", memw_cnt, 0);
      check_cnt("illegal_pcwrite", pcw_cnt, 3);

      // reset during a MEMRD stall, then a normal instruction
      do_reset(0, 1);
      gen_instr(0, 6'd35, 0, 5); run(0, 6);
      do_reset(0, 2);
      gen_instr(0, 6'd0, 1, 0); run(0, -1);
      check_cnt("post_reset_regwrite", regw_cnt, 1);

      // randomized instruction streams on every parameter set
      for (int sel = 0; sel < 3; sel++) begin
         do_reset(sel, 1);
         for (int k = 0; k < 25; k++) begin
            logic [5:0] op;
            case ($urandom_range(0, 6))
               0: op = 6'd0;
               1: op = 6'd35;
               2: op = 6'd43;
               3: op = 6'd4;
               4: op = 6'd8;
               5: op = 6'd2;
               default: op = 6'($urandom);
            endcase
            gen_instr(sel, op, $urandom_range(0, 3), $urandom_range(0, 3));
         end
         run(sel, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
